// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential 6502-style ALU: op codes, FSM states and the flag record.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OpOr  = 4'h0,
        OpAnd = 4'h1,
        OpXor = 4'h2,
        OpAdc = 4'h3,
        OpSbc = 4'h4,
        OpAsl = 4'h5,
        OpLsr = 4'h6,
        OpRol = 4'h7,
        OpRor = 4'h8,
        OpInc = 4'h9,
        OpDec = 4'hA,
        OpCmp = 4'hB
    } alu_op_t;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StDadj = 2'd2,
        StDone = 2'd3
    } alu_state_t;

    typedef struct packed {
        logic n;
        logic v;
        logic z;
        logic c;
    } alu_flags_t;

    localparam int unsigned FlagN = 3;
    localparam int unsigned FlagV = 2;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagC = 0;

    function automatic logic is_add_sub(input alu_op_t op);
        return (op == OpAdc) || (op == OpSbc);
    endfunction

endpackage

// File: rtl/ripple_adder_n.sv
// Plain ripple-carry adder; the single binary adder behind ADC, SBC, CMP, INC and DEC.
module ripple_adder_n #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             c_in,
    output logic [WIDTH-1:0] Sum,
    output logic             c_out
);

    logic [WIDTH:0] carry;

    always_comb begin
        carry    = '0;
        Sum      = '0;
        carry[0] = c_in;
        for (int i = 0; i < int'(WIDTH); i++) begin
            Sum[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i+1]   = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        c_out = carry[WIDTH];
    end

endmodule

// File: rtl/alu_seq_6502.sv
// Sequential 6502-style ALU: one op per handshake, binary in EXEC, optional BCD fix-up in DADJ.
// Decimal mode is compiled in only when ALU_SEQ_DECIMAL_EN is defined.
module alu_seq_6502
    import alu_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int unsigned NumNib = WIDTH / 4;
    localparam int unsigned NibW   = (NumNib > 1) ? $clog2(NumNib) : 1;

    alu_state_t       state_q;
    alu_op_t          op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             cin_q;
    alu_flags_t       flags_q;
    logic             in_ready_q, out_valid_q;

    logic [WIDTH-1:0] add_b, add_sum, exec_res;
    logic             add_cin, add_cout;
    alu_flags_t       exec_flags;
    logic             go_dadj;

    ripple_adder_n #(
        .WIDTH (WIDTH)
    ) u_adder (
        .A     (a_q),
        .B     (add_b),
        .c_in  (add_cin),
        .Sum   (add_sum),
        .c_out (add_cout)
    );

    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        case (op_q)
            OpAdc: begin add_b = b_q;  add_cin = cin_q; end
            OpSbc: begin add_b = ~b_q; add_cin = cin_q; end
            OpCmp: begin add_b = ~b_q; add_cin = 1'b1;  end
            OpInc: begin add_b = '0;   add_cin = 1'b1;  end
            OpDec: begin add_b = '1;   add_cin = 1'b0;  end
            default: ;
        endcase
    end

    // Undefined op codes fall through with a zero result, so Z comes out 1 and the rest 0.
    always_comb begin
        exec_res   = '0;
        exec_flags = '0;
        case (op_q)
            OpOr:  exec_res = a_q | b_q;
            OpAnd: exec_res = a_q & b_q;
            OpXor: exec_res = a_q ^ b_q;
            OpAdc, OpSbc: begin
                exec_res     = add_sum;
                exec_flags.c = add_cout;
                exec_flags.v = (a_q[WIDTH-1] == add_b[WIDTH-1]) &&
                               (add_sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OpCmp: begin
                exec_res     = add_sum;
                exec_flags.c = add_cout;
            end
            OpInc, OpDec: begin
                exec_res     = add_sum;
                exec_flags.c = cin_q;
            end
            OpAsl: begin
                exec_res     = {a_q[WIDTH-2:0], 1'b0};
                exec_flags.c = a_q[WIDTH-1];
            end
            OpLsr: begin
                exec_res     = {1'b0, a_q[WIDTH-1:1]};
                exec_flags.c = a_q[0];
            end
            OpRol: begin
                exec_res     = {a_q[WIDTH-2:0], cin_q};
                exec_flags.c = a_q[WIDTH-1];
            end
            OpRor: begin
                exec_res     = {cin_q, a_q[WIDTH-1:1]};
                exec_flags.c = a_q[0];
            end
            default: ;
        endcase
        exec_flags.n = exec_res[WIDTH-1];
        exec_flags.z = (exec_res == '0);
    end

`ifdef ALU_SEQ_DECIMAL_EN
    logic             dec_q;
    logic [NibW-1:0]  nib_q;
    logic             dc_q;     // digit carry for ADC, digit borrow for SBC
    logic [NibW+1:0]  nib_sh;
    logic [3:0]       nib_a, nib_b, dnib;
    logic [5:0]       dsum;
    logic             dcarry, nib_last;
    logic [WIDTH-1:0] dres;

    assign go_dadj = dec_q && is_add_sub(op_q);

    always_comb begin
        nib_sh   = {nib_q, 2'b00};
        nib_a    = 4'(a_q >> nib_sh);
        nib_b    = 4'(b_q >> nib_sh);
        nib_last = (nib_q == NibW'(NumNib - 1));
        dcarry   = 1'b0;
        if (op_q == OpSbc) begin
            // Six-bit two's complement: bit 5 set means the digit went negative.
            dsum = {2'b00, nib_a} - {2'b00, nib_b} - {5'b0, dc_q};
            if (dsum[5]) begin
                dsum   = dsum - 6'd6;
                dcarry = 1'b1;
            end
        end else begin
            dsum = {2'b00, nib_a} + {2'b00, nib_b} + {5'b0, dc_q};
            if (dsum > 6'd9) begin
                dsum   = dsum + 6'd6;
                dcarry = 1'b1;
            end
        end
        dnib = dsum[3:0];
        dres = (result_q & ~(WIDTH'(4'hF) << nib_sh)) | (WIDTH'(dnib) << nib_sh);
    end
`else
    logic unused_decimal;
    assign unused_decimal = decimal;
    assign go_dadj        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            op_q        <= OpOr;
            a_q         <= '0;
            b_q         <= '0;
            cin_q       <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef ALU_SEQ_DECIMAL_EN
            dec_q       <= 1'b0;
            nib_q       <= '0;
            dc_q        <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_q       <= op;
                        a_q        <= operand_a;
                        b_q        <= operand_b;
                        cin_q      <= carry_in;
`ifdef ALU_SEQ_DECIMAL_EN
                        dec_q      <= decimal;
`endif
                        in_ready_q <= 1'b0;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    result_q <= exec_res;
                    flags_q  <= exec_flags;
                    if (go_dadj) begin
                        state_q <= StDadj;
`ifdef ALU_SEQ_DECIMAL_EN
                        nib_q   <= '0;
                        dc_q    <= (op_q == OpSbc) ? ~cin_q : cin_q;
`endif
                    end else begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
                end
                StDadj: begin
`ifdef ALU_SEQ_DECIMAL_EN
                    result_q <= dres;
                    nib_q    <= nib_q + NibW'(1);
                    dc_q     <= dcarry;
                    if (nib_last) begin
                        flags_q.n   <= dres[WIDTH-1];
                        flags_q.z   <= (dres == '0);
                        flags_q.c   <= (op_q == OpSbc) ? ~dcarry : dcarry;
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                    end
`else
                    state_q <= StIdle;
`endif
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        flags        = '0;
        flags[FlagN] = flags_q.n;
        flags[FlagV] = flags_q.v;
        flags[FlagZ] = flags_q.z;
        flags[FlagC] = flags_q.c;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_seq_6502.sv
// Directed bench for alu_seq_6502 (WIDTH=8): vector table plus stall and reset sequences.
module tb_alu_seq_6502;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    alu_op_t    op;
    logic [7:0] operand_a, operand_b;
    logic       carry_in, decimal;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;

    int n_cmp  = 0;
    int n_fail = 0;

    alu_seq_6502 #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .carry_in  (carry_in),
        .decimal   (decimal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        alu_op_t    op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       dec;
        logic [7:0] res;
        logic [3:0] flg;   // {N,V,Z,C}
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op and wait for out_valid; leaves the DUT in DONE with out_ready low.
    // lat is in cycles from the accept cycle T, so binary ops should report 2.
    task automatic issue(input alu_op_t o, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic dec, output int lat);
        @(negedge clk);
        op        = o;
        operand_a = a;
        operand_b = b;
        carry_in  = cin;
        decimal   = dec;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release_result();
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic add_vec(input string name, input alu_op_t o, input logic [7:0] a,
                           input logic [7:0] b, input logic cin, input logic dec,
                           input logic [7:0] res, input logic [3:0] flg, input int lat);
        vec_t v;
        v.name = name; v.op = o; v.a = a; v.b = b; v.cin = cin; v.dec = dec;
        v.res = res; v.flg = flg; v.lat = lat;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [7:0] held_res;
        logic [3:0] held_flg;

        //      name          op     a      b      cin   dec   res    NVZC     lat
        add_vec("adc_ovf",    OpAdc, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b1100, 2);
        add_vec("sbc_borrow", OpSbc, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b1000, 2);
        add_vec("cmp_equal",  OpCmp, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 4'b0011, 2);
        add_vec("ror_fill",   OpRor, 8'h01, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1001, 2);
        add_vec("asl_out",    OpAsl, 8'h80, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0011, 2);
        add_vec("or",         OpOr,  8'h0F, 8'hF0, 1'b0, 1'b0, 8'hFF, 4'b1000, 2);
        add_vec("and_zero",   OpAnd, 8'h0F, 8'hF0, 1'b1, 1'b0, 8'h00, 4'b0010, 2);
        add_vec("xor",        OpXor, 8'hAA, 8'hFF, 1'b1, 1'b0, 8'h55, 4'b0000, 2);
        add_vec("lsr",        OpLsr, 8'h03, 8'h00, 1'b0, 1'b0, 8'h01, 4'b0001, 2);
        add_vec("rol_fill",   OpRol, 8'h80, 8'h00, 1'b1, 1'b0, 8'h01, 4'b0001, 2);
        add_vec("inc_wrap",   OpInc, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 4'b0010, 2);
        add_vec("inc_cin",    OpInc, 8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 4'b1001, 2);
        add_vec("dec_wrap",   OpDec, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 4'b1001, 2);
        add_vec("cmp_less",   OpCmp, 8'h05, 8'h06, 1'b1, 1'b0, 8'hFF, 4'b1000, 2);
        add_vec("adc_cin_v",  OpAdc, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h81, 4'b1100, 2);
        add_vec("sbc_v",      OpSbc, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 4'b0101, 2);
        add_vec("adc_carry",  OpAdc, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 4'b0011, 2);
        add_vec("undef_op",   alu_op_t'(4'hC), 8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 4'b0010, 2);
`ifdef ALU_SEQ_DECIMAL_EN
        add_vec("bcd_adc",    OpAdc, 8'h19, 8'h28, 1'b0, 1'b1, 8'h47, 4'b0000, 4);
        add_vec("bcd_adc_99", OpAdc, 8'h99, 8'h01, 1'b0, 1'b1, 8'h00, 4'b0011, 4);
        add_vec("bcd_sbc_0",  OpSbc, 8'h00, 8'h01, 1'b1, 1'b1, 8'h99, 4'b1000, 4);
        add_vec("bcd_sbc",    OpSbc, 8'h50, 8'h25, 1'b1, 1'b1, 8'h25, 4'b0001, 4);
        add_vec("bcd_nonbcd", OpAdc, 8'h0F, 8'h00, 1'b0, 1'b1, 8'h15, 4'b0000, 4);
        add_vec("bcd_ign_or", OpOr,  8'h19, 8'h28, 1'b0, 1'b1, 8'h39, 4'b0000, 2);
`else
        add_vec("dec_ignored", OpAdc, 8'h19, 8'h28, 1'b0, 1'b1, 8'h41, 4'b0000, 2);
        add_vec("dec_ign_sbc", OpSbc, 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 4'b1000, 2);
`endif

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        op        = OpOr;
        operand_a = '0;
        operand_b = '0;
        carry_in  = 1'b0;
        decimal   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;

        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result",    32'(result),    32'd0);
        check("reset_flags",     32'(flags),     32'd0);

        foreach (vecs[i]) begin
            check({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].dec, lat);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_result"},  32'(result), 32'(vecs[i].res));
            check({vecs[i].name, "_flags"},   32'(flags),  32'(vecs[i].flg));
            release_result();
        end

        // Hold the consumer off for five cycles: output must not move, no new accept.
        issue(OpAdc, 8'h50, 8'h50, 1'b0, 1'b0, lat);
        held_res = 8'hA0;
        held_flg = 4'b1100;
        @(negedge clk) in_valid = 1'b1;
        op = OpXor; operand_a = 8'h0F; operand_b = 8'h01;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("stall_result",    32'(result),    32'(held_res));
            check("stall_flags",     32'(flags),     32'(held_flg));
            check("stall_in_ready",  32'(in_ready),  32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_result();
        check("stall_back_idle", 32'(in_ready), 32'd1);

        // Reset while a result is parked in DONE clears it.
        issue(OpAdc, 8'h50, 8'h50, 1'b0, 1'b0, lat);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_done_in_ready",  32'(in_ready),  32'd1);
        check("rst_done_out_valid", 32'(out_valid), 32'd0);
        check("rst_done_result",    32'(result),    32'd0);
        check("rst_done_flags",     32'(flags),     32'd0);
        @(negedge clk) reset_n = 1'b1;

        // Reset in the middle of an operation (DADJ when decimal is built in).
        @(negedge clk);
        op = OpAdc; operand_a = 8'h99; operand_b = 8'h99; carry_in = 1'b1; decimal = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_in_ready",  32'(in_ready),  32'd1);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_result",    32'(result),    32'd0);
        check("rst_mid_flags",     32'(flags),     32'd0);
        @(negedge clk) reset_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_no_result", 32'(out_valid), 32'd0);

        // Clean operation after the abandoned one.
        issue(OpRor, 8'h01, 8'h00, 1'b1, 1'b0, lat);
        check("post_rst_latency", 32'(lat),    32'd2);
        check("post_rst_result",  32'(result), 32'h80);
        check("post_rst_flags",   32'(flags),  32'b1001);
        release_result();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
